// File: rtl/pes_siso.sv
// Serial-in serial-out shift register of DEPTH 1-bit stages with synchronous clear.
// Latency: a bit sampled at edge N is on serial_out just after edge N+DEPTH-1.
// Backpressure: none; shifts unconditionally on every non-reset rising edge.
module pes_siso #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic serial_out
);

  // stage[0] is the entry stage and stage[DEPTH-1] is the exit stage.
  logic [DEPTH-1:0] stage;

  // Clear every stage on reset; otherwise capture serial_in and advance the chain by one.
  // Reset wins over shifting, so an X on serial_in during reset never enters the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= serial_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // The output comes straight from the exit register, so there is no combinational path from serial_in.
  assign serial_out = stage[DEPTH-1];

endmodule

// File: tb/tb_pes_siso.sv
module tb_pes_siso;

  logic clk;
  logic reset;
  logic serial_in;
  logic out4;
  logic out1;
  logic out8;

  int total = 0;
  int bad   = 0;

  // Inputs the DUTs have shifted in since the last reset edge, oldest first.
  bit seen[$];

  pes_siso #(.DEPTH(4)) u_dut4 (.clk(clk), .reset(reset), .serial_in(serial_in), .serial_out(out4));
  pes_siso #(.DEPTH(1)) u_dut1 (.clk(clk), .reset(reset), .serial_in(serial_in), .serial_out(out1));
  pes_siso #(.DEPTH(8)) u_dut8 (.clk(clk), .reset(reset), .serial_in(serial_in), .serial_out(out8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // A delay line of depth d: the bit entered d edges ago, or 0 if fewer than d bits since reset.
  function automatic logic model_out(input int d);
    if (seen.size() >= d) return seen[seen.size() - d];
    return 1'b0;
  endfunction

  // Apply one clock edge with the given reset and data, optionally glitching serial_in
  // between edges, then check all three instances against the model.
  task automatic drive_edge(input logic rst_v, input logic din, input bit glitch);
    @(negedge clk);
    reset = rst_v;
    if (glitch) begin
      serial_in = ~din;
      #1 serial_in = din;
      #1 serial_in = ~din;
      #1 serial_in = din;
      #1 serial_in = ~din;
      // Outputs must not have moved while the input was toggling.
      chk("hold4", out4, model_out(4));
      chk("hold8", out8, model_out(8));
      serial_in = din;
    end else begin
      serial_in = din;
    end
    @(posedge clk);
    #1;
    if (rst_v) seen.delete();
    else seen.push_back(din);
    chk("d4", out4, model_out(4));
    chk("d1", out1, model_out(1));
    chk("d8", out8, model_out(8));
  endtask

  logic [14:0] stream_in;
  logic [14:0] stream_exp;

  initial begin
    reset     = 1'b1;
    serial_in = 1'bx;

    // Reset clear with an unknown input: all outputs are 0 just after the reset edge.
    @(posedge clk);
    #1;
    chk("rst4", out4, 1'b0);
    chk("rst1", out1, 1'b0);
    chk("rst8", out8, 1'b0);

    // Single 1 followed by zeros: only the 4th post-reset edge shows 1 on the depth-4 instance.
    drive_edge(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      drive_edge(1'b0, (k == 1) ? 1'b1 : 1'b0, 1'b0);
      chk("single", out4, (k == 4) ? 1'b1 : 1'b0);
    end

    // Stream ordering against a fixed expected table (index 0 is the first edge).
    drive_edge(1'b1, 1'b0, 1'b0);
    stream_in  = 15'b101011010110101;
    stream_exp = 15'b000101011010110;
    for (int k = 0; k < 15; k++) begin
      drive_edge(1'b0, stream_in[14-k], 1'b0);
      chk("stream", out4, stream_exp[14-k]);
    end
    chk("stream_in15", serial_in, 1'b1);

    // Mid-stream reset: fill with ones, reset with serial_in=1, then zeros keep the output low.
    for (int k = 0; k < 4; k++) drive_edge(1'b0, 1'b1, 1'b0);
    chk("filled", out4, 1'b1);
    drive_edge(1'b1, 1'b1, 1'b0);
    chk("midrst", out4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_edge(1'b0, 1'b0, 1'b0);
      chk("postrst", out4, 1'b0);
    end

    // Glitch immunity: only the value settled at the edge is shifted in.
    for (int k = 0; k < 12; k++) begin
      drive_edge(1'b0, logic'(k % 3 == 0), 1'b1);
    end

    // Randomized traffic with occasional resets and glitches for all three depths.
    for (int k = 0; k < 400; k++) begin
      drive_edge(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pes_siso.md
PES_SISO -- requirements
Module: pes_siso

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of shift stages; legal range is DEPTH >= 1.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-004 The module SHALL have port serial_in, input, 1 bit: the serial data bit captured into stage 0 on each rising edge of clk.
REQ-005 The module SHALL have port serial_out, output, 1 bit: the registered value of the last stage, stage DEPTH-1.
REQ-006 The module SHALL have no other ports.

Function
REQ-007 Internal state SHALL be a chain of DEPTH 1-bit registers, stage[0] to stage[DEPTH-1].
REQ-008 On each rising edge of clk with reset low, stage[0] SHALL load serial_in and stage[i] SHALL load stage[i-1] for i = 1..DEPTH-1.
REQ-009 The module SHALL have no enable: it shifts on every non-reset clock edge.
REQ-010 serial_out SHALL be driven directly by stage[DEPTH-1], with no combinational path from serial_in to serial_out.
REQ-011 Latency: the value of serial_in sampled at edge N SHALL appear on serial_out just after edge N+DEPTH-1 (DEPTH edges in total, counting edge N), and SHALL remain there until edge N+DEPTH.
REQ-012 With DEPTH = 1, the module SHALL behave as a single D flip-flop with synchronous clear.
REQ-013 serial_out SHALL change only on a rising edge of clk.
REQ-014 Input changes between clock edges SHALL NOT affect state.
REQ-015 Data ordering SHALL be first-in first-out: bits leave serial_out in the same order they entered.

Reset
REQ-016 When reset is high at a rising edge of clk, all stages SHALL become 0, and serial_out SHALL therefore be 0 after that edge.
REQ-017 Reset SHALL take priority over shifting; serial_in is ignored on reset edges.
REQ-018 Asserting reset mid-stream SHALL discard all in-flight bits.
REQ-019 After reset deasserts, serial_out SHALL output 0 for the first DEPTH-1 shift edges, and the first post-reset serial_in bit SHALL appear after the DEPTH-th edge.
REQ-020 Before the first reset edge, stage contents are unspecified; X on serial_in during reset SHALL NOT propagate.

Verification
Clock period 10; serial_in changes mid-cycle.

REQ-021 Reset clear: hold reset=1 for 1 edge with serial_in=X, then deassert -> serial_out=0 immediately after the reset edge.

REQ-022 Single-bit latency (DEPTH=4): after reset, drive one 1 then all 0s -> serial_out=1 after exactly the 4th post-reset edge only, and 0 otherwise.

REQ-023 Stream ordering (DEPTH=4): after reset, drive 1,0,1,0,1,1,0,1,0,1,1,0,1,0,1 on 15 consecutive edges -> serial_out after each edge is 0,0,0,1,0,1,0,1,1,0,1,0,1,1,0. After the 15th edge serial_in=1 and serial_out=0.

REQ-024 Mid-stream reset: fill with 1111, then assert reset for 1 edge with serial_in=1 -> serial_out=0 on that edge. With serial_in=0 afterwards, serial_out stays 0 for the following 4 edges.

REQ-025 Glitch immunity: toggle serial_in several times between edges -> only the value present at the edge is shifted in.

REQ-026 Parameter sweep: DEPTH=1 and DEPTH=8 with random serial_in -> serial_out equals serial_in delayed by DEPTH edges against a reference model.
